// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master sequencer (START, addr+RW, ACK, data, ACK, STOP).
// Optional slave clock stretching is enabled by defining I2C_MASTER_CLK_STRETCH_EN.
module i2c_master_ctrl #(
   parameter int DIV_QTR = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_i,
   input  logic       sda_i
);
   localparam int CW = (DIV_QTR > 1) ? $clog2(DIV_QTR) : 1;
   typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] abyte_q, abyte_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic nack_q, nack_d;
   logic active, freeze, tick, sample, last;
   assign active = state_q != IDLE && state_q != DONE;
`ifdef I2C_MASTER_CLK_STRETCH_EN
   // Hold the quarter while a released SCL is still being held low by a slave.
   assign freeze = active && !scl_oe && !scl_i;
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign freeze = 1'b0;
`endif
   // Bus drive and handshake outputs decoded from state and quarter position.
   always_comb begin
      cmd_ready = state_q == IDLE;
      busy = active;
      rsp_valid = state_q == DONE;
      rsp_rdata = rdata_q;
      rsp_nack = nack_q;
      scl_oe = 1'b0;
      sda_oe = 1'b0;
      case (state_q)
         START: sda_oe = 1'b1;
         ADDR: begin
            scl_oe = !qtr_q[1];
            sda_oe = !abyte_q[3'd7 - bit_q];
         end
         DATA: begin
            scl_oe = !qtr_q[1];
            sda_oe = !abyte_q[0] && !wdata_q[3'd7 - bit_q];
         end
         ADDR_ACK, DATA_ACK: scl_oe = !qtr_q[1];
         STOP: begin
            scl_oe = qtr_q == 2'd0;
            sda_oe = qtr_q != 2'd2;
         end
         default: ;
      endcase
   end
   // Prescaler, quarter/bit sequencing, command capture and response sampling.
   always_comb begin
      state_d = state_q;
      qtr_d = qtr_q;
      bit_d = bit_q;
      abyte_d = abyte_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      nack_d = nack_q;
      tick = active && !freeze && cnt_q == CW'(DIV_QTR - 1);
      sample = tick && qtr_q == 2'd1;
      last = tick && (state_q == START ? qtr_q == 2'd1 : state_q == STOP ? qtr_q == 2'd2 : qtr_q == 2'd3);
      cnt_d = (!active || tick) ? '0 : freeze ? cnt_q : cnt_q + 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d = START;
            abyte_d = {cmd_addr, cmd_rw};
            wdata_d = cmd_wdata;
            rdata_d = 8'h00;
            nack_d = 1'b0;
            bit_d = 3'd0;
         end
         START: if (last) state_d = ADDR;
         ADDR: if (last) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ADDR_ACK;
         end
         ADDR_ACK: begin
            if (sample) nack_d = sda_i;
            if (last) state_d = nack_q ? STOP : DATA;
         end
         DATA: begin
            if (sample && abyte_q[0]) rdata_d = {rdata_q[6:0], sda_i};
            if (last) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = DATA_ACK;
            end
         end
         DATA_ACK: begin
            if (sample && !abyte_q[0]) nack_d = sda_i;
            if (last) state_d = STOP;
         end
         STOP: if (last) state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) qtr_d = 2'd0;
   end
   // State register; reset releases the bus immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         qtr_q <= 2'd0;
         bit_q <= 3'd0;
         abyte_q <= 8'h00;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         nack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         qtr_q <= qtr_d;
         bit_q <= bit_d;
         abyte_q <= abyte_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         nack_q <= nack_d;
      end
   end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed and randomized transfers against a bus-level slave model.
module tb_i2c_master_ctrl;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cmd_valid = 1'b0, cmd_rw = 1'b0;
   logic [6:0] cmd_addr = 7'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
   logic [7:0] rsp_rdata;
   logic hold = 1'b0, slv_low = 1'b0;
   logic scl_line, sda_line;
   assign scl_line = !(scl_oe || hold);
   assign sda_line = !(sda_oe || slv_low);
   always #5 clk = ~clk;
   i2c_master_ctrl #(.DIV_QTR(D)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_line), .sda_i(sda_line)
   );
   int checks = 0, errors = 0;
   logic [6:0] slv_addr = 7'h42;
   logic ack_en = 1'b1, dack_en = 1'b1, stretch = 1'b0;
   logic [7:0] slv_tx = 8'h00, sh = 8'h00;
   logic sel = 1'b0, rd = 1'b0, ps = 1'b1, pd = 1'b1, mack = 1'b0;
   int bitn = -1, rises = 0, n_start = 0, n_stop = 0, hc = 0, hw_bad = 0, hcnt = 0;
   logic [7:0] seen[$];
   // Slave: decodes START/STOP and SCL edges from mid-cycle samples of the wired bus.
   always @(negedge clk) begin
      ps <= scl_line;
      pd <= sda_line;
      hc <= scl_line ? hc + 1 : 0;
      if (ps && !scl_line && bitn >= 1 && hc != 2 * D) hw_bad <= hw_bad + 1;
      if (ps && scl_line && pd && !sda_line) begin
         bitn <= 0;
         n_start <= n_start + 1;
         slv_low <= 1'b0;
         sel <= 1'b0;
      end else if (ps && scl_line && !pd && sda_line) begin
         bitn <= -1;
         n_stop <= n_stop + 1;
         rises <= bitn;
         slv_low <= 1'b0;
      end else if (!ps && scl_line && bitn >= 0) begin
         bitn <= bitn + 1;
         if (bitn != 8 && bitn != 17) sh <= {sh[6:0], sda_line};
         if (bitn == 7 || bitn == 16) seen.push_back({sh[6:0], sda_line});
         if (bitn == 17) mack <= sda_line;
      end else if (ps && !scl_line && bitn >= 0) begin
         if (bitn == 8) begin
            sel <= ack_en && sh[7:1] == slv_addr;
            rd <= sh[0];
            slv_low <= ack_en && sh[7:1] == slv_addr;
         end else if (bitn >= 9 && bitn <= 16) slv_low <= sel && rd && !slv_tx[3'(16 - bitn)];
         else if (bitn == 17) slv_low <= sel && !rd && dack_en;
         else slv_low <= 1'b0;
         if (bitn == 8 && stretch) begin
            hold <= 1'b1;
            hcnt <= 0;
         end
      end
      if (hold && !scl_oe) begin
         hcnt <= hcnt + 1;
         if (hcnt == 20) hold <= 1'b0;
      end
   end
   int cyc = 0, acc_cyc = 0, rsp_cyc = 0, n_acc = 0, n_rsp = 0;
   // Timestamps of accepts and responses in clk cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready && !rst) begin
         acc_cyc <= cyc;
         n_acc <= n_acc + 1;
      end
      if (rsp_valid) begin
         rsp_cyc <= cyc;
         n_rsp <= n_rsp + 1;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_rsp(input int n);
      int t = 0;
      while (n_rsp < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("rsp_seen", n_rsp >= n, 1);
   endtask
   task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd);
      int n0 = n_acc;
      int t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr = a;
      cmd_rw = rw;
      cmd_wdata = wd;
      while (n_acc == n0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      cmd_valid = 1'b0;
      cmd_addr = 7'($urandom);
      cmd_rw = 1'($urandom);
      cmd_wdata = 8'($urandom);
      chk("accepted", n_acc != n0, 1);
      chk("rsp_cleared", {rsp_nack, rsp_rdata}, 9'h000);
   endtask
   // One transfer; expectations follow from the byte-level protocol rules.
   task automatic xact(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic match,
                       input logic dack, input logic [7:0] tx, input int extra);
      int s0, p0, nr, si, exp_lat;
      logic exp_nack;
      logic [7:0] exp_rd;
      slv_addr = match ? a : a ^ 7'h01;
      dack_en = dack;
      slv_tx = tx;
      exp_nack = !match || (!rw && !dack);
      exp_rd = (match && rw) ? tx : 8'h00;
      exp_lat = (2 + 9 * 4 + (match ? 9 * 4 : 0) + 3) * D + 1 + extra;
      s0 = n_start;
      p0 = n_stop;
      nr = n_rsp;
      si = seen.size();
      issue(a, rw, wd);
      chk("busy", busy, 1);
      wait_rsp(nr + 1);
      chk("latency", rsp_cyc - acc_cyc, exp_lat);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_nack", rsp_nack, exp_nack);
      repeat (6) @(negedge clk);
      chk("rsp_hold", {rsp_nack, rsp_rdata}, {exp_nack, exp_rd});
      chk("idle", {busy, cmd_ready, rsp_valid}, 3'b010);
      chk("addr_byte", seen[si], {a, rw});
      chk("nbytes", seen.size() - si, match ? 2 : 1);
      if (match) chk("data_byte", seen[si + 1], rw ? tx : wd);
      if (match) chk("ack9", mack, rw ? 1'b1 : !dack);
      // nine SCL pulses per byte slot plus the SCL release ahead of STOP
      chk("scl_pulses", rises, match ? 19 : 10);
      chk("starts", n_start - s0, 1);
      chk("stops", n_stop - p0, 1);
      chk("scl_high", hw_bad, 0);
   endtask
   initial begin
      #100_0000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int t, n0, nr, s0, p0, si;
      #1 rst = 1'b1;
      #1;
      chk("rst_scl_oe", scl_oe, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 8'h00);
      chk("rst_nack", rsp_nack, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      xact(7'h42, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
      xact(7'h21, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 0);
      xact(7'h42, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 0);
      xact(7'h42, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 0);
      slv_addr = 7'h42;
      dack_en = 1'b1;
      s0 = n_start;
      p0 = n_stop;
      si = seen.size();
      nr = n_rsp;
      n0 = n_acc;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr = 7'h42;
      cmd_rw = 1'b0;
      cmd_wdata = 8'h11;
      t = 0;
      while (n_acc == n0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      cmd_wdata = 8'h22;
      t = 0;
      while (n_acc < n0 + 2 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", n_acc - n0, 2);
      chk("b2b_gap", acc_cyc - rsp_cyc, 1);
      wait_rsp(nr + 2);
      repeat (6) @(negedge clk);
      chk("b2b_a0", seen[si], 8'h84);
      chk("b2b_d0", seen[si + 1], 8'h11);
      chk("b2b_a1", seen[si + 2], 8'h84);
      chk("b2b_d1", seen[si + 3], 8'h22);
      chk("b2b_starts", n_start - s0, 2);
      chk("b2b_stops", n_stop - p0, 2);
      chk("b2b_scl_high", hw_bad, 0);
      issue(7'h42, 1'b0, 8'hC3);
      t = 0;
      while (!(bitn == 12 && !scl_line) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("mid_reached", bitn, 12);
      rst = 1'b1;
      #1;
      chk("mid_rst_scl", scl_oe, 0);
      chk("mid_rst_sda", sda_oe, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);
      repeat (4) @(negedge clk);
      xact(7'h42, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 0);
`ifdef I2C_MASTER_CLK_STRETCH_EN
      stretch = 1'b1;
      xact(7'h42, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 20);
`else
      xact(7'h42, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 0);
`endif
      stretch = 1'b0;
      for (int i = 0; i < 8; i++) begin
         xact(7'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), 0);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master transaction sequencer that drives the open-drain SCL/SDA bus shared with i2c_slave.
- Accepts one command per transfer (7-bit address, R/W, write byte) and generates the full sequence: START, address+RW, ACK, data, ACK, STOP.
- Returns the read data and a NACK flag.
- Used as the bus-side controller in system-level benches and in the SoC-level I2C subsystem.

Parameters:
- DIV_QTR, 25: clk cycles per quarter SCL bit period (SCL period = 4*DIV_QTR clk). Minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_addr  in  7  target address
- cmd_rw  in  1  1 = read, 0 = write
- cmd_wdata  in  8  write byte (ignored on read)
- rsp_valid  out  1  one-cycle pulse at end of transfer
- rsp_rdata  out  8  read byte (0x00 on write or NACK)
- rsp_nack  out  1  1 = address or write-data NACK seen
- busy  out  1  high from accept through end of STOP
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- scl_i  in  1  sampled SCL line
- sda_i  in  1  sampled SDA line

Behaviour:
- Reset (async, immediate): scl_oe=0, sda_oe=0 (bus released), cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00, rsp_nack=0, state IDLE.
  - Reset mid-transfer releases the bus without generating STOP.
- Quarter tick: a prescaler produces one tick every DIV_QTR clk. It restarts at the accept edge and is held at 0 in IDLE. All bus changes occur on ticks.
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
- Bit slot (4 quarters):
  - q0: SCL low; drive SDA to the bit (0 → sda_oe=1, 1 → release).
  - q1: release SCL.
  - q2: SCL high; sample sda_i at entry.
  - q3: SCL high, then pull SCL low at exit.
- START (2 quarters): SCL released; sda_oe=1 in both quarters.
- ADDR: 8 slots, MSB first, carrying {cmd_addr, cmd_rw}.
- ADDR_ACK: 1 slot with SDA released. sda_i=1 → rsp_nack=1 and go to STOP; otherwise go to DATA.
- DATA:
  - Write: 8 slots of cmd_wdata, MSB first.
  - Read: SDA released; shift sda_i MSB first into rsp_rdata.
- DATA_ACK:
  - Write: SDA released; sample sda_i; a 1 sets rsp_nack.
  - Read: master sends NACK (SDA released), since transfers are single-byte.
- STOP (3 quarters):
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low.
  - q2: SDA released.
- DONE: 1 clk. rsp_valid=1, busy drops, then IDLE. rsp_rdata/rsp_nack hold until the next accept, which clears them.
- Latency, accept edge to rsp_valid (no stretching):
  - Full transfer: 77*DIV_QTR+1 clk.
  - Address NACK: 41*DIV_QTR+1 clk.
- Commands: cmd_valid while busy is ignored (cmd_ready=0). A command held valid across DONE is accepted on the first IDLE cycle, so back-to-back commands are separated by exactly 1 idle clk.
- cmd_* fields are captured at accept; later changes have no effect.

Optional Feature:
- Macro: I2C_MASTER_CLK_STRETCH_EN.
- Enabled:
  - In q1 of every slot and of STOP, the prescaler is frozen while scl_i=0 after SCL is released (slave clock stretching).
  - The quarter resumes counting from the first clk where scl_i=1.
- Disabled: scl_i is unused and timing is fixed.

Test Plan:
- Write: addr 0x42, wdata 0xA5, DIV_QTR=4, slave ACKs → SDA bytes 0x84 then 0xA5 observed; rsp_valid at accept+309 clk; rsp_nack=0; rsp_rdata=0x00.
- Address NACK: addr 0x21, no slave response → STOP follows ADDR_ACK; rsp_valid at accept+165 clk; rsp_nack=1; no data slots on the bus.
- Read: addr 0x42, slave returns 0x3C → SDA byte 0x85; rsp_rdata=0x3C; master NACK in the ninth data slot; rsp_nack=0.
- Back-to-back: cmd_valid held for two write commands (0x11, 0x22) → second accepted 1 clk after the first rsp_valid; two START/STOP pairs; SCL high width always 2*DIV_QTR clk.
- Reset mid-transfer: assert rst during DATA bit 3 → scl_oe=sda_oe=0 in the same cycle; cmd_ready=1 after release; next write completes normally.
- Stretch (macro on): slave holds SCL low 20 clk in q1 of the ADDR_ACK slot → rsp_valid delayed by exactly 20 clk versus the unstretched run. With the macro off, timing is unchanged.
